// File: rtl/cache_wb_drain_queue.sv
// ---------------------------------------------------------------------------
// cache_wb_drain_queue
//
// Write-back drain queue that sits behind the write-back cache data store.
// Evicted lines (line address, full line data, per-byte dirty mask) are
// buffered in a small FIFO. Each line is drained as memory write beats in
// ascending beat order, and beats that hold no dirty bytes are skipped. An
// address lookup lets the bank hold a miss fill to a line that is still
// waiting for write-back.
//
// Handshakes (evict_* and mem_req_*) use plain valid/ready. A transfer
// happens on a rising clock edge where valid and ready are both high. The
// source keeps its payload stable while valid && !ready. Ready never depends
// on valid.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   evict_valid       evicted line offered
//   evict_addr        line address of evicted line
//   evict_data        full line data
//   evict_byteen      per-byte dirty mask (all zero = clean, consumed only)
//   evict_ready       queue has a free entry
//   mem_req_valid     memory write beat valid
//   mem_req_addr      {line address, beat index}
//   mem_req_data      beat data
//   mem_req_byteen    beat byte mask (dirty bytes only)
//   mem_req_ready     memory accepts beat
//   lookup_addr       line address probed by the bank
//   lookup_hit        lookup_addr matches a queued or draining line
//   empty             no line queued or draining
//   count             occupied entries
//   dbg_state_o       drain FSM state (0 = IDLE, 1 = SEND)
// ---------------------------------------------------------------------------
module cache_wb_drain_queue #(
  parameter int LINE_SIZE     = 64,
  parameter int MEM_DATA_SIZE = 16,
  parameter int ADDR_WIDTH    = 26,
  parameter int DEPTH         = 4,
  localparam int BEATS        = LINE_SIZE / MEM_DATA_SIZE,
  localparam int BEAT_BITS    = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int PW           = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            evict_valid,
  input  logic [ADDR_WIDTH-1:0]           evict_addr,
  input  logic [LINE_SIZE*8-1:0]          evict_data,
  input  logic [LINE_SIZE-1:0]            evict_byteen,
  output logic                            evict_ready,
  output logic                            mem_req_valid,
  output logic [ADDR_WIDTH+BEAT_BITS-1:0] mem_req_addr,
  output logic [MEM_DATA_SIZE*8-1:0]      mem_req_data,
  output logic [MEM_DATA_SIZE-1:0]        mem_req_byteen,
  input  logic                            mem_req_ready,
  input  logic [ADDR_WIDTH-1:0]           lookup_addr,
  output logic                            lookup_hit,
  output logic                            empty,
  output logic [PW:0]                     count,
  output logic                            dbg_state_o
);

  localparam int MDW = MEM_DATA_SIZE * 8;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_e;

  // FIFO storage and pointers
  logic [ADDR_WIDTH-1:0]  addr_mem_q [DEPTH];
  logic [LINE_SIZE*8-1:0] data_mem_q [DEPTH];
  logic [LINE_SIZE-1:0]   ben_mem_q  [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW:0]            count_q, count_d;

  // Drain FSM and registered memory-request outputs
  state_e                          state_q;
  logic [BEAT_BITS-1:0]            beat_q;
  logic                            req_valid_q;
  logic [ADDR_WIDTH+BEAT_BITS-1:0] req_addr_q;
  logic [MDW-1:0]                  req_data_q;
  logic [MEM_DATA_SIZE-1:0]        req_ben_q;

  logic                   push, pop, req_hs;
  logic [ADDR_WIDTH-1:0]  head_addr;
  logic [LINE_SIZE*8-1:0] head_data;
  logic [LINE_SIZE-1:0]   head_ben;
  logic [BEATS-1:0]       beat_dirty;
  logic [BEAT_BITS-1:0]   first_beat, next_beat, sel_beat;
  logic                   next_found;
  logic [MDW-1:0]         sel_data;
  logic [MEM_DATA_SIZE-1:0] sel_ben;
  logic [PW-1:0]          offs [DEPTH];

  assign evict_ready    = (count_q != FULL_CNT);
  assign empty          = (count_q == '0);
  assign count          = count_q;
  assign mem_req_valid  = req_valid_q;
  assign mem_req_addr   = req_addr_q;
  assign mem_req_data   = req_data_q;
  assign mem_req_byteen = req_ben_q;
  assign dbg_state_o    = (state_q == S_SEND);

  // A clean line is consumed by the handshake but never stored.
  assign push   = evict_valid && evict_ready && (|evict_byteen);
  assign req_hs = req_valid_q && mem_req_ready;
  // The head stays in the FIFO until its last dirty beat is accepted.
  assign pop    = req_hs && !next_found;

  assign head_addr = addr_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];
  assign head_ben  = ben_mem_q[rd_ptr_q];

  always_comb begin
    beat_dirty = '0;
    for (int b = 0; b < BEATS; b++) begin
      beat_dirty[b] = |head_ben[b*MEM_DATA_SIZE +: MEM_DATA_SIZE];
    end
  end

  // Scanning downwards leaves the lowest matching beat in each result.
  always_comb begin
    first_beat = '0;
    next_beat  = '0;
    next_found = 1'b0;
    for (int b = BEATS-1; b >= 0; b--) begin
      if (beat_dirty[b]) begin
        first_beat = BEAT_BITS'(b);
        if (b > int'(beat_q)) begin
          next_beat  = BEAT_BITS'(b);
          next_found = 1'b1;
        end
      end
    end
  end

  assign sel_beat = (state_q == S_IDLE) ? first_beat : next_beat;
  assign sel_data = head_data[int'(sel_beat)*MDW +: MDW];
  assign sel_ben  = head_ben[int'(sel_beat)*MEM_DATA_SIZE +: MEM_DATA_SIZE];

  // An entry is valid when its distance from the read pointer is below count.
  always_comb begin
    lookup_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      offs[i] = PW'(i) - rd_ptr_q;
      if (({1'b0, offs[i]} < count_q) && (addr_mem_q[i] == lookup_addr)) begin
        lookup_hit = 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity comes only from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= evict_addr;
      data_mem_q[wr_ptr_q] <= evict_data;
      ben_mem_q[wr_ptr_q]  <= evict_byteen;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_ben_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            state_q     <= S_SEND;
            req_valid_q <= 1'b1;
            beat_q      <= sel_beat;
            req_addr_q  <= {head_addr, sel_beat};
            req_data_q  <= sel_data;
            req_ben_q   <= sel_ben;
          end
        end
        S_SEND: begin
          if (req_hs) begin
            if (next_found) begin
              beat_q     <= sel_beat;
              req_addr_q <= {head_addr, sel_beat};
              req_data_q <= sel_data;
              req_ben_q  <= sel_ben;
            end else begin
              // Last beat of the line: return to IDLE, which gives one bubble cycle.
              state_q     <= S_IDLE;
              req_valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_wb_drain_queue.sv
// ---------------------------------------------------------------------------
// tb_cache_wb_drain_queue
//
// Bench for cache_wb_drain_queue using the default geometry (64-byte lines,
// 16-byte beats, 4 entries). The reference model lists the lines that are
// still pending. For each line it holds the write beats expected from its
// dirty mask. Occupancy, lookup hits and beat contents all come from this
// list.
// ---------------------------------------------------------------------------
module tb_cache_wb_drain_queue;

  localparam int LS    = 64;
  localparam int MDS   = 16;
  localparam int AW    = 26;
  localparam int DEPTH = 4;
  localparam int BEATS = LS / MDS;
  localparam int BB    = 2;
  localparam int MAW   = AW + BB;
  localparam int BW    = MAW + MDS*8 + MDS;

  logic              clk;
  logic              reset;
  logic              evict_valid;
  logic [AW-1:0]     evict_addr;
  logic [LS*8-1:0]   evict_data;
  logic [LS-1:0]     evict_byteen;
  logic              evict_ready;
  logic              mem_req_valid;
  logic [MAW-1:0]    mem_req_addr;
  logic [MDS*8-1:0]  mem_req_data;
  logic [MDS-1:0]    mem_req_byteen;
  logic              mem_req_ready;
  logic [AW-1:0]     lookup_addr;
  logic              lookup_hit;
  logic              empty;
  logic [2:0]        count;
  logic              dbg_state;

  cache_wb_drain_queue #(
    .LINE_SIZE(LS), .MEM_DATA_SIZE(MDS), .ADDR_WIDTH(AW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .evict_valid(evict_valid), .evict_addr(evict_addr), .evict_data(evict_data),
    .evict_byteen(evict_byteen), .evict_ready(evict_ready),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_byteen(mem_req_byteen),
    .mem_req_ready(mem_req_ready),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
    .empty(empty), .count(count), .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] exp_q[$];
  logic [AW-1:0] line_addr_q[$];
  int            line_beats_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic          hold_v = 1'b0;
  logic [BW-1:0] hold_beat;
  logic          cont_v = 1'b0;
  logic          accepted = 1'b0;
  int            hs_total = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [BW-1:0] cur_beat();
    return {mem_req_addr, mem_req_data, mem_req_byteen};
  endfunction

  // Checks done once per cycle on the falling edge against the model.
  task automatic check_cycle();
    logic hit;
    int   sz;
    sz  = line_addr_q.size();
    hit = 1'b0;
    foreach (line_addr_q[i]) if (line_addr_q[i] == lookup_addr) hit = 1'b1;
    chk("count", count, sz);
    chk("empty", empty, (sz == 0));
    chk("evict_ready", evict_ready, (sz != DEPTH));
    chk("lookup_hit", lookup_hit, hit);
    chk("spurious_beat", (mem_req_valid && exp_q.size() == 0), 1'b0);
    if (hold_v) chk("stall_hold", {mem_req_valid, cur_beat()}, {1'b1, hold_beat});
    if (cont_v) chk("burst_gap", mem_req_valid, 1'b1);
  endtask

  // Applies the coming rising edge to the model.
  task automatic update_model();
    logic           rdy;
    logic [MDS-1:0] sl;
    int             nb;
    rdy      = (line_addr_q.size() != DEPTH);
    hold_v   = 1'b0;
    cont_v   = 1'b0;
    accepted = 1'b0;
    if (reset) begin
      exp_q.delete();
      line_addr_q.delete();
      line_beats_q.delete();
      return;
    end
    if (mem_req_valid && mem_req_ready) begin
      hs_total++;
      if (exp_q.size() > 0) begin
        chk("beat", cur_beat(), exp_q[0]);
        void'(exp_q.pop_front());
        line_beats_q[0] = line_beats_q[0] - 1;
        if (line_beats_q[0] == 0) begin
          void'(line_beats_q.pop_front());
          void'(line_addr_q.pop_front());
        end else begin
          cont_v = 1'b1;
        end
      end
    end else if (mem_req_valid) begin
      hold_v    = 1'b1;
      hold_beat = cur_beat();
    end
    if (evict_valid && rdy) begin
      accepted = 1'b1;
      if (evict_byteen != '0) begin
        nb = 0;
        for (int b = 0; b < BEATS; b++) begin
          sl = evict_byteen[b*MDS +: MDS];
          if (sl != '0) begin
            exp_q.push_back({evict_addr, BB'(b), evict_data[b*MDS*8 +: MDS*8], sl});
            nb++;
          end
        end
        line_addr_q.push_back(evict_addr);
        line_beats_q.push_back(nb);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    check_cycle();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [AW-1:0] a, input logic [511:0] d, input logic [63:0] be);
    evict_valid  = 1'b1;
    evict_addr   = a;
    evict_data   = d;
    evict_byteen = be;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (accepted) break;
    end
    chk("offer_accepted", accepted, 1'b1);
    evict_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget && line_addr_q.size() != 0; n++) tick();
    chk("drain_done", line_addr_q.size(), 0);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    evict_valid = 1'b0; evict_addr = '0; evict_data = '0; evict_byteen = '0;
    mem_req_ready = 1'b0; lookup_addr = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_valid", mem_req_valid, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_hit", lookup_hit, 1'b0);
    chk("rst_ready", evict_ready, 1'b1);
    mem_req_ready = 1'b1;

    // fully dirty line, four consecutive beats 0x40..0x43
    offer(26'h10, rnd512(), {64{1'b1}});
    drain(40);

    // single dirty beat 1, bytes 16..19 of the line
    offer(26'h22, rnd512(), 64'h000F_0000);
    drain(40);

    // clean line is consumed but never stored
    lookup_addr = 26'h33;
    offer(26'h33, rnd512(), 64'h0);
    repeat (5) tick();

    // fill to full with memory stalled, then release
    mem_req_ready = 1'b0;
    offer(26'h100, rnd512(), {64{1'b1}});
    offer(26'h101, rnd512(), 64'hF000_0000_0000_00F0);
    offer(26'h102, rnd512(), 64'h0000_FFFF_0000_0001);
    offer(26'h103, rnd512(), {64{1'b1}});
    evict_valid = 1'b1; evict_addr = 26'h104; evict_byteen = {64{1'b1}};
    repeat (3) tick();
    evict_valid = 1'b0;
    lookup_addr = 26'h100;
    #1 chk("full_hit_A", lookup_hit, 1'b1);
    chk("full_count", count, 4);
    chk("full_ready", evict_ready, 1'b0);
    lookup_addr = 26'h1FF;
    #1 chk("full_miss_E", lookup_hit, 1'b0);
    mem_req_ready = 1'b1;
    drain(80);

    // memory ready toggling every cycle through a four-beat line
    mem_req_ready = 1'b0;
    offer(26'h2A, rnd512(), {64{1'b1}});
    for (int n = 0; n < 60 && line_addr_q.size() != 0; n++) begin
      mem_req_ready = ~mem_req_ready;
      tick();
    end
    chk("toggle_drained", line_addr_q.size(), 0);
    mem_req_ready = 1'b1;
    tick();

    // reset while beat 2 of 4 is presented
    begin
      int h0;
      lookup_addr = 26'h3C;
      offer(26'h3C, rnd512(), {64{1'b1}});
      h0 = hs_total;
      for (int n = 0; n < 50 && hs_total < h0 + 2; n++) tick();
      chk("mid_burst_reached", hs_total - h0, 2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("rst_mid_valid", mem_req_valid, 1'b0);
      chk("rst_mid_count", count, 0);
      chk("rst_mid_empty", empty, 1'b1);
      chk("rst_mid_hit", lookup_hit, 1'b0);
      tick();
    end

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      int mode;
      evict_valid   = ($urandom_range(0, 2) == 0);
      evict_addr    = AW'($urandom_range(0, 7));
      evict_data    = rnd512();
      mode          = $urandom_range(0, 3);
      evict_byteen  = '0;
      if (mode == 1) evict_byteen = {64{1'b1}};
      else if (mode >= 2) begin
        for (int b = 0; b < BEATS; b++)
          if ($urandom_range(0, 1) == 1) evict_byteen[b*MDS +: MDS] = MDS'($urandom_range(1, 65535));
      end
      mem_req_ready = ($urandom_range(0, 3) != 0);
      lookup_addr   = AW'($urandom_range(0, 9));
      reset         = ($urandom_range(0, 299) == 0);
      tick();
      reset = 1'b0;
    end
    evict_valid   = 1'b0;
    mem_req_ready = 1'b1;
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
